zero_count_sequencer: RTL

//   Multi-cycle controller that scans a captured WIDTH-bit word one bit per cycle.
//   It accumulates the number of zero bits found.

---
 rtl/zero_count_sequencer_if.sv | 34 +++
 rtl/zero_count_sequencer.sv | 100 ++++++++++
 2 files changed

// File: rtl/zero_count_sequencer_if.sv
// Handshake bundle for zero_count_sequencer.
// Define ZCS_ONES_MODE_EN to add count_ones.
interface zero_count_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             enable;
  logic             start;
  logic [WIDTH-1:0] number;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
`ifdef ZCS_ONES_MODE_EN
  logic             count_ones;

  modport master (
    output enable, start, number, count_ones,
    input  busy, done, count
  );
  modport slave (
    input  enable, start, number, count_ones,
    output busy, done, count
  );
`else
  modport master (
    output enable, start, number,
    input  busy, done, count
  );
  modport slave (
    input  enable, start, number,
    output busy, done, count
  );
`endif
endinterface

// File: rtl/zero_count_sequencer.sv
// Bounded one-bit-per-cycle zero counter with start/busy/done.
// ZCS_ONES_MODE_EN adds a latched count-ones mode.
module zero_count_sequencer #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH) + 1,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic CLK,
  input logic RST,
  zero_count_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam int SEL_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] word;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] count_q;
  logic             busy_q;
  logic             done_q;
  logic             cur;
  logic             hit;
`ifdef ZCS_ONES_MODE_EN
  logic             ones_q;
`endif

  // Bit under the scan index and whether it should be counted.
  always_comb begin
    cur = word[idx[SEL_W-1:0]];
`ifdef ZCS_ONES_MODE_EN
    hit = ones_q ? cur : ~cur;
`else
    hit = ~cur;
`endif
  end

  // Scan FSM with registered busy/done/count.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      word    <= '0;
      idx     <= '0;
      acc     <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ZCS_ONES_MODE_EN
      ones_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            word   <= bus.number;
            idx    <= '0;
            acc    <= '0;
            busy_q <= 1'b1;
            state  <= SCAN;
`ifdef ZCS_ONES_MODE_EN
            ones_q <= bus.count_ones;
`endif
          end
        end
        SCAN: begin
          if (bus.enable) begin
            acc <= acc + CNT_W'(hit);
            idx <= idx + 1'b1;
            if (idx == LAST) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          count_q <= acc;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.count = count_q;

endmodule
